wb_mem_responder: RTL and testbench

- Wishbone-classic responder (slave) memory: the far end of the core's instruction/data bus.
- Accepts single read/write transactions from the core-side initiator (cyc/stb/we/wstrb/addr/data).
- Backs them with a word-organised RAM and returns ack after a programmable wait-state count.
- Used in simulation benches and as the on-FPGA program/data memory behind the bus wrapper.

---
 rtl/wb_mem_responder.sv | 132 +++++++++++++
 tb/tb_wb_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone-classic responder backed by a word-organised RAM.
// Accepts one read or write per bus cycle and acks after LATENCY wait states.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   cyc_i    - bus cycle active; dropping it while waiting aborts the transfer
//   stb_i    - transfer strobe, sampled only in IDLE
//   we_i     - 1 = write, 0 = read
//   wstrb_i  - byte-lane write enables (bit n -> data bits [8n+7:8n])
//   addr_i   - byte address
//   data_i   - write data
//   data_o   - read data, valid while ack_o = 1, otherwise 0
//   ack_o    - one-cycle transfer-complete pulse
//   err_o    - out-of-range access, pulses together with ack_o
//
// state | meaning
// IDLE  | waiting for cyc_i & stb_i; request is latched on acceptance
// WAIT  | counting down wait states; cyc_i low aborts
// ACK   | ack_o (and err_o/data_o) driven for exactly one cycle
//
// WAIT is entered on every acceptance and completes on the edge where the
// counter is zero, so ack_o rises LATENCY+1 cycles after the acceptance edge
// (also for LATENCY = 0). The RAM write and the read-data load happen on that
// same completing edge.

module wb_mem_responder #(
  parameter int          MEM_DEPTH_WORDS = 4096,
  parameter int          LATENCY         = 1,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter string       MEMORY_FILE     = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int          AW   = $clog2(MEM_DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [31:0]   mem [MEM_DEPTH_WORDS];

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic          lat_we;
  logic [3:0]    lat_wstrb;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_data;
  logic          lat_err;

  logic [31:0]   offset;
  logic          in_range;
  logic          accept;
  logic          complete;

  // Offset wraps when addr_i < BASE_ADDR, hence the explicit lower-bound test.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = (addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign accept   = (state == S_IDLE) && cyc_i && stb_i;
  assign complete = (state == S_WAIT) && cyc_i && (wait_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      data_o    <= 32'h0;
      lat_we    <= 1'b0;
      lat_wstrb <= 4'h0;
      lat_idx   <= '0;
      lat_data  <= 32'h0;
      lat_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_we    <= we_i;
            lat_wstrb <= wstrb_i;
            lat_idx   <= offset[AW+1:2];
            lat_data  <= data_i;
            lat_err   <= !in_range;
            wait_cnt  <= LAT;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!cyc_i) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state  <= S_ACK;
            ack_o  <= 1'b1;
            err_o  <= lat_err;
            data_o <= (!lat_we && !lat_err) ? mem[lat_idx] : 32'h0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACK: begin
          state  <= S_IDLE;
          ack_o  <= 1'b0;
          err_o  <= 1'b0;
          data_o <= 32'h0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; reset forces IDLE so a pending write can never complete.
  always_ff @(posedge clk) begin
    if (complete && lat_we && !lat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_wstrb[b]) mem[lat_idx][8*b +: 8] <= lat_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
module tb_wb_mem_responder;

  localparam int N = 5;
  localparam int LATS [N] = '{1, 0, 3, 15, 4};

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc   [N];
  logic        stb   [N];
  logic        we    [N];
  logic [3:0]  wstrb [N];
  logic [31:0] addr  [N];
  logic [31:0] wdat  [N];
  logic [31:0] rdat  [N];
  logic        ack   [N];
  logic        err   [N];

  exp_t        sb [$];
  logic [31:0] mdl [int];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      wb_mem_responder #(.LATENCY(LATS[g])) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cyc_i   (cyc[g]),
        .stb_i   (stb[g]),
        .we_i    (we[g]),
        .wstrb_i (wstrb[g]),
        .addr_i  (addr[g]),
        .data_i  (wdat[g]),
        .data_o  (rdat[g]),
        .ack_o   (ack[g]),
        .err_o   (err[g])
      );
    end
  endgenerate

  // Builds the expected response into the scoreboard and updates the model.
  task automatic push_expect(input int sel, input logic w, input logic [3:0] strb,
                             input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] word;
    bit          oor;
    int          key;
    oor = (a >= 32'h4000);
    key = sel * 8192 + int'(a[13:2]);
    e.err = oor;
    if (w || oor) e.data = 32'h0;
    else          e.data = mdl.exists(key) ? mdl[key] : 32'h0;
    if (w && !oor) begin
      word = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (strb[b]) word[8*b +: 8] = d[8*b +: 8];
      mdl[key] = word;
    end
    sb.push_back(e);
  endtask

  task automatic bus_xfer(input int sel, input logic w, input logic [3:0] strb,
                          input logic [31:0] a, input logic [31:0] d, input string name);
    exp_t e;
    int   n;
    bit   got;
    push_expect(sel, w, strb, a, d);
    @(negedge clk);
    cyc[sel] = 1'b1; stb[sel] = 1'b1; we[sel] = w;
    wstrb[sel] = strb; addr[sel] = a; wdat[sel] = d;
    @(posedge clk); #1;
    stb[sel] = 1'b0;
    addr[sel] = ~a; wdat[sel] = ~d;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack[sel]) got = 1;
    end
    e = sb.pop_front();
    n_total++;
    if (!got) begin
      $display("FAIL %s ack timeout: no ack after %0d cycles, required %0d", name, n, LATS[sel] + 1);
    end else begin
      n_pass++;
      n_total++;
      if (n !== LATS[sel] + 1) $display("FAIL %s latency: got %0d required %0d", name, n, LATS[sel] + 1);
      else n_pass++;
      n_total++;
      if (rdat[sel] !== e.data) $display("FAIL %s data: got %h required %h", name, rdat[sel], e.data);
      else n_pass++;
      n_total++;
      if (err[sel] !== e.err) $display("FAIL %s err: got %b required %b", name, err[sel], e.err);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (ack[sel] !== 1'b0 || err[sel] !== 1'b0 || rdat[sel] !== 32'h0)
        $display("FAIL %s pulse: ack=%b err=%b data=%h one cycle later, required 0/0/0",
                 name, ack[sel], err[sel], rdat[sel]);
      else n_pass++;
    end
    cyc[sel] = 1'b0; we[sel] = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int s = 0; s < N; s++) begin
      n_total++;
      if (ack[s] !== 1'b0 || err[s] !== 1'b0 || rdat[s] !== 32'h0)
        $display("FAIL reset[%0d]: ack=%b err=%b data=%h required 0/0/0", s, ack[s], err[s], rdat[s]);
      else n_pass++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic_read();
    bus_xfer(0, 1'b1, 4'hF, 32'h0, 32'hDEAD_BEEF, "w0_deadbeef");
    bus_xfer(0, 1'b0, 4'h0, 32'h0, 32'h0, "r0_deadbeef");
  endtask

  task automatic test_byte_lanes();
    bus_xfer(0, 1'b1, 4'b1111, 32'h10, 32'h1122_3344, "lane_full");
    bus_xfer(0, 1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD, "lane_0101");
    bus_xfer(0, 1'b0, 4'h0,    32'h10, 32'h0,         "lane_read");
    bus_xfer(0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, "lane_noop");
    bus_xfer(0, 1'b0, 4'h0,    32'h13, 32'h0,         "lane_unaligned_read");
  endtask

  task automatic test_latency_sweep();
    for (int s = 1; s <= 3; s++) begin
      bus_xfer(s, 1'b1, 4'hF, 32'h40, 32'h0BAD_0000 + 32'(s), $sformatf("lat%0d_w", LATS[s]));
      bus_xfer(s, 1'b0, 4'h0, 32'h40, 32'h0, $sformatf("lat%0d_r", LATS[s]));
    end
  endtask

  task automatic test_out_of_range();
    bus_xfer(0, 1'b1, 4'hF, 32'h4000, 32'h5555_5555, "oor_write");
    bus_xfer(0, 1'b0, 4'h0, 32'h4000, 32'h0, "oor_read");
    bus_xfer(0, 1'b0, 4'h0, 32'h0, 32'h0, "oor_word0_intact");
  endtask

  task automatic test_abort();
    int acks;
    bus_xfer(4, 1'b1, 4'hF, 32'h20, 32'h1234_5678, "abort_prior");
    @(negedge clk);
    cyc[4] = 1'b1; stb[4] = 1'b1; we[4] = 1'b1;
    wstrb[4] = 4'hF; addr[4] = 32'h20; wdat[4] = 32'hCAFE_F00D;
    @(posedge clk); #1 stb[4] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 cyc[4] = 1'b0;
    acks = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ack[4]) acks++;
    end
    n_total++;
    if (acks !== 0) $display("FAIL abort_no_ack: got %0d acks required 0", acks);
    else n_pass++;
    we[4] = 1'b0;
    bus_xfer(4, 1'b0, 4'h0, 32'h20, 32'h0, "abort_read_prior");
  endtask

  task automatic test_async_reset();
    bus_xfer(4, 1'b1, 4'hF, 32'h30, 32'hA5A5_0030, "rst_prior");
    @(negedge clk);
    cyc[4] = 1'b1; stb[4] = 1'b1; we[4] = 1'b1;
    wstrb[4] = 4'hF; addr[4] = 32'h30; wdat[4] = 32'h5A5A_FFFF;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
    @(posedge clk); #1 stb[4] = 1'b0; stb[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    n_total++;
    if (ack[0] !== 1'b1 || rdat[0] !== 32'hDEAD_BEEF)
      $display("FAIL rst_pre_ack: ack=%b data=%h required 1/deadbeef", ack[0], rdat[0]);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (ack[0] !== 1'b0 || err[0] !== 1'b0 || rdat[0] !== 32'h0)
      $display("FAIL rst_async: ack=%b err=%b data=%h required 0/0/0", ack[0], err[0], rdat[0]);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (ack[4] !== 1'b0) $display("FAIL rst_wait_ack: ack=%b required 0", ack[4]);
    else n_pass++;
    cyc[0] = 1'b0; cyc[4] = 1'b0; we[4] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    bus_xfer(4, 1'b0, 4'h0, 32'h30, 32'h0, "rst_no_write");
    bus_xfer(0, 1'b0, 4'h0, 32'h10, 32'h0, "rst_after_normal");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   acks;
    int   cycles;
    push_expect(0, 1'b0, 4'h0, 32'h10, 32'h0);
    push_expect(0, 1'b0, 4'h0, 32'h10, 32'h0);
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    acks = 0; cycles = 0;
    while (acks < 2 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (ack[0]) begin
        acks++;
        e = sb.pop_front();
        n_total++;
        if (rdat[0] !== e.data || err[0] !== e.err)
          $display("FAIL b2b_ack%0d: data=%h err=%b required %h/%b", acks, rdat[0], err[0], e.data, e.err);
        else n_pass++;
        if (acks == 2) stb[0] = 1'b0;
      end
    end
    stb[0] = 1'b0;
    n_total++;
    if (acks !== 2) $display("FAIL b2b_count: got %0d acks required 2", acks);
    else n_pass++;
    while (sb.size() > 0) void'(sb.pop_front());
    @(posedge clk); #1 cyc[0] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < N; s++) begin
      cyc[s] = 1'b0; stb[s] = 1'b0; we[s] = 1'b0;
      wstrb[s] = 4'h0; addr[s] = 32'h0; wdat[s] = 32'h0;
    end
    test_reset();
    test_basic_read();
    test_byte_lanes();
    test_latency_sweep();
    test_out_of_range();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
